// File: rtl/gomoku_board_ctrl.sv
// Two-player Gomoku controller: board, cursor, turn alternation and 4-cycle win check.
// Define GOMOKU_UNDO_EN to compile in the circular undo history and the undo button.
module gomoku_board_ctrl #(
    parameter int MAP_N      = 10,
    parameter int WIN_LEN    = 5,
    parameter int UNDO_DEPTH = 8,
    parameter int POS_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       left,
    input  logic                       right,
    input  logic                       up,
    input  logic                       down,
    input  logic                       put,
    input  logic                       undo,
    output logic [2*MAP_N*MAP_N-1:0]   board_state,
    output logic [POS_W-1:0]           cursor_pos,
    output logic                       turn,
    output logic                       busy,
    output logic                       put_ack,
    output logic                       put_nack,
    output logic [1:0]                 winner,
    output logic                       game_over
);

    localparam int CELLS   = MAP_N * MAP_N;
    localparam int BOARD_W = 2 * CELLS;
    localparam int IDX_W   = $clog2(CELLS);
    localparam int RC_W    = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_OVER  = 2'd2;

    localparam int B_LEFT  = 0;
    localparam int B_RIGHT = 1;
    localparam int B_UP    = 2;
    localparam int B_DOWN  = 3;
    localparam int B_PUT   = 4;
    localparam int B_UNDO  = 5;

    logic [BOARD_W-1:0] board;
    logic [1:0]         state;
    logic [1:0]         dir;
    logic               win_flag;
    logic [RC_W-1:0]    cur_row;
    logic [RC_W-1:0]    cur_col;
    logic [RC_W-1:0]    lat_row;
    logic [RC_W-1:0]    lat_col;
    logic [1:0]         lat_color;
    logic [5:0]         btn;
    logic [5:0]         btn_q;
    logic [5:0]         btn_edge;
    logic [IDX_W-1:0]   cur_idx;
    logic [1:0]         cursor_cell;
    logic               place;
    int                 dr;
    int                 dc;
    int                 line_total;
    logic               line_win;

    assign btn      = {undo, put, down, up, right, left};
    assign btn_edge = btn & ~btn_q;

    assign cur_idx     = IDX_W'(cur_row) * IDX_W'(MAP_N) + IDX_W'(cur_col);
    assign cursor_cell = board[{cur_idx, 1'b0} +: 2];
    assign place       = (state == S_IDLE) && btn_edge[B_PUT] && (cursor_cell == 2'b00);

    assign board_state = board;
    assign cursor_pos  = POS_W'(cur_idx);
    assign busy        = (state == S_CHECK);
    assign game_over   = (state == S_OVER);

    // Stones of `color` walking away from (r0,c0) in steps of (sr,sc), stopping at an edge or mismatch.
    function automatic int run_len(input logic [BOARD_W-1:0] b, input int r0, input int c0,
                                   input int sr, input int sc, input logic [1:0] color);
        int               n;
        int               r;
        int               c;
        logic             alive;
        logic [IDX_W-1:0] idx;
        n     = 0;
        alive = 1'b1;
        for (int k = 1; k < WIN_LEN; k++) begin
            r = r0 + k * sr;
            c = c0 + k * sc;
            if (r < 0 || r >= MAP_N || c < 0 || c >= MAP_N) begin
                alive = 1'b0;
            end else begin
                idx = IDX_W'(r * MAP_N + c);
                if (b[{idx, 1'b0} +: 2] != color) alive = 1'b0;
            end
            if (alive) n = n + 1;
        end
        return n;
    endfunction

    // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        dr = 0;
        dc = 1;
        case (dir)
            2'd0:    begin dr = 0;  dc = 1; end
            2'd1:    begin dr = 1;  dc = 0; end
            2'd2:    begin dr = 1;  dc = 1; end
            default: begin dr = -1; dc = 1; end
        endcase
        line_total = 1
                   + run_len(board, int'(lat_row), int'(lat_col), dr, dc, lat_color)
                   + run_len(board, int'(lat_row), int'(lat_col), -dr, -dc, lat_color);
    end

    assign line_win = (line_total >= WIN_LEN);

`ifdef GOMOKU_UNDO_EN
    localparam int PTR_W = $clog2(UNDO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [2*RC_W-1:0] hist [UNDO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  hist_count;
    logic [RC_W-1:0]   pop_row;
    logic [RC_W-1:0]   pop_col;
    logic [IDX_W-1:0]  pop_idx;
    logic              undo_go;

    assign rd_ptr             = wr_ptr - 1'b1;
    assign {pop_row, pop_col} = hist[rd_ptr];
    assign pop_idx            = IDX_W'(pop_row) * IDX_W'(MAP_N) + IDX_W'(pop_col);
    // A simultaneous put edge always wins over undo.
    assign undo_go = btn_edge[B_UNDO] && !btn_edge[B_PUT] && (state != S_CHECK)
                   && (hist_count != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            hist_count <= '0;
        end else if (place) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (hist_count != CNT_W'(UNDO_DEPTH)) hist_count <= hist_count + 1'b1;
        end else if (undo_go) begin
            wr_ptr     <= rd_ptr;
            hist_count <= hist_count - 1'b1;
        end
    end

    // NOTE: history storage has no reset; hist_count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (place) hist[wr_ptr] <= {cur_row, cur_col};
    end
`else
    logic unused_undo;
    assign unused_undo = btn_edge[B_UNDO];
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            board     <= '0;
            state     <= S_IDLE;
            dir       <= 2'd0;
            win_flag  <= 1'b0;
            cur_row   <= RC_W'(MAP_N / 2);
            cur_col   <= RC_W'(MAP_N / 2);
            lat_row   <= '0;
            lat_col   <= '0;
            lat_color <= 2'b00;
            btn_q     <= '0;
            turn      <= 1'b0;
            winner    <= 2'b00;
            put_ack   <= 1'b0;
            put_nack  <= 1'b0;
        end else begin
            btn_q    <= btn;
            put_ack  <= 1'b0;
            put_nack <= 1'b0;

            // One move per cycle; a higher-priority move blocked at an edge still masks the rest.
            if (btn_edge[B_RIGHT]) begin
                if (cur_col != RC_W'(MAP_N - 1)) cur_col <= cur_col + 1'b1;
            end else if (btn_edge[B_LEFT]) begin
                if (cur_col != '0) cur_col <= cur_col - 1'b1;
            end else if (btn_edge[B_UP]) begin
                if (cur_row != '0) cur_row <= cur_row - 1'b1;
            end else if (btn_edge[B_DOWN]) begin
                if (cur_row != RC_W'(MAP_N - 1)) cur_row <= cur_row + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (place) begin
                        board[{cur_idx, 1'b0} +: 2] <= turn ? 2'b10 : 2'b01;
                        lat_row   <= cur_row;
                        lat_col   <= cur_col;
                        lat_color <= turn ? 2'b10 : 2'b01;
                        put_ack   <= 1'b1;
                        dir       <= 2'd0;
                        win_flag  <= 1'b0;
                        state     <= S_CHECK;
                    end else if (btn_edge[B_PUT]) begin
                        put_nack <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (btn_edge[B_PUT]) put_nack <= 1'b1;
                    dir      <= dir + 1'b1;
                    win_flag <= win_flag | line_win;
                    if (dir == 2'd3) begin
                        if (win_flag || line_win) begin
                            winner <= lat_color;
                            state  <= S_OVER;
                        end else begin
                            turn  <= ~turn;
                            state <= S_IDLE;
                        end
                    end
                end
                S_OVER: begin
                    if (btn_edge[B_PUT]) put_nack <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase

`ifdef GOMOKU_UNDO_EN
            // Undo overrides any cursor move sampled in the same cycle.
            if (undo_go) begin
                board[{pop_idx, 1'b0} +: 2] <= 2'b00;
                cur_row  <= pop_row;
                cur_col  <= pop_col;
                turn     <= (board[{pop_idx, 1'b0} +: 2] == 2'b10);
                winner   <= 2'b00;
                win_flag <= 1'b0;
                state    <= S_IDLE;
            end
`endif
        end
    end

endmodule

// File: doc/gomoku_board_ctrl.md
# gomoku_board_ctrl

Parametrised two-player Gomoku game controller. It holds the board as a 2-bit-per-cell state vector and owns the cursor. It accepts stone placements with an occupancy check, alternates turns, and runs a 4-cycle win-detection sequence after every placement. It sits between the push-button inputs and the LCD renderer, which consumes `board_state`, `cursor_pos` and `winner`.

## Interface
- `MAP_N`, default 10: board is MAP_N × MAP_N intersections; legal range 5..15.
- `WIN_LEN`, default 5: contiguous same-colour stones needed to win; legal range 3..MAP_N.
- `UNDO_DEPTH`, default 8: undo history entries; power of two.
- `POS_W`, default 8: cell index width; must satisfy 2^POS_W ≥ MAP_N².

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `left`, `right`, `up`, `down`  in  1 each  cursor buttons, level inputs; rising edge detected internally.
- `put`  in  1  place-stone button, level input; rising edge detected.
- `undo`  in  1  undo button, level input; rising edge detected.
- `board_state`  out  2·MAP_N²  cell k = row·MAP_N+col at bits [2k+1:2k]; 00 empty, 01 black, 10 white.
- `cursor_pos`  out  POS_W  current cell index.
- `turn`  out  1  0 = black to move, 1 = white to move.
- `busy`  out  1  high while in CHECK.
- `put_ack`, `put_nack`  out  1 each  one-cycle pulses reporting put outcome.
- `winner`  out  2  00 none, 01 black, 10 white.
- `game_over`  out  1  high in OVER.

## Operation
- Reset (`rst`=0 at a clk edge) sets the following:
  - `board_state` = 0.
  - `cursor_pos` = (MAP_N/2)·MAP_N + MAP_N/2, which is 55 for the default.
  - `turn` = 0, `busy` = 0, `put_ack` = 0, `put_nack` = 0, `winner` = 00, `game_over` = 0.
  - Undo count = 0 and all edge-detect registers = 0.
  - State → IDLE.
  - Reset mid-CHECK aborts the check with no winner.
- Edge detection: a button registers as pressed when its input is 1 and its registered previous value is 0.
- Cursor moves are accepted in every state. Only one move is applied per cycle, with priority right > left > up > down.
  - right: +1, unless col = MAP_N−1.
  - left: −1, unless col = 0.
  - up: −MAP_N, unless row = 0.
  - down: +MAP_N, unless row = MAP_N−1.
  - A move blocked at an edge is ignored; there is no wrap-around.
- FSM IDLE:
  - A put edge on an empty cell writes the colour (turn ? 10 : 01) at `cursor_pos`, latches that position, pushes it onto the undo history, pulses `put_ack`, and goes to CHECK.
  - A put edge on an occupied cell pulses `put_nack`; the state is unchanged.
- FSM CHECK: lasts exactly 4 cycles, direction d = 0..3 (horizontal, vertical, diagonal ↘, diagonal ↗).
  - Each cycle counts contiguous same-colour stones from the latched position on both sides of direction d. Each side counts up to WIN_LEN−1 and stops at an edge or a mismatch. The total is 1 + left-side count + right-side count.
  - If the total ≥ WIN_LEN (overlines count as wins), the block sets a sticky win flag.
  - After d = 3: if the win flag is set, it sets `winner` to the placed colour and goes to OVER. Otherwise it toggles `turn` and goes to IDLE.
  - A put edge while in CHECK pulses `put_nack`.
- FSM OVER: a put edge pulses `put_nack`. Only reset or undo (when compiled in) leaves OVER.
- Simultaneous put and undo edges: put is processed and undo is dropped.
- Undo (in IDLE or OVER, count > 0):
  - Pops the last position, clears that cell to 00, and sets `cursor_pos` to that position.
  - Sets `turn` to the colour of the removed stone and clears `winner`, `game_over` and the win flag.
  - State → IDLE.
  - Undo with count = 0, or undo while in CHECK, is ignored.
- Undo history is a circular buffer of UNDO_DEPTH entries. A push when full overwrites the oldest entry, and the count saturates at UNDO_DEPTH.

## Timing
- Let edge E be the clk edge at which the put edge is sampled. At E:
  - `board_state`, `put_ack` (1 cycle) and `busy` all update; these values are visible after E.
  - The CHECK cycles are E+1 .. E+4.
  - At E+4, `busy` falls and either `turn` toggles or `winner`/`game_over` are set.
- Put-to-result latency: 4 cycles after board update; the next put is accepted from edge E+5 onward.
- `put_nack` is a one-cycle pulse in the cycle after the rejected edge is sampled. The board is unchanged.
- Cursor and undo updates are visible one cycle after the sampling edge.
- Holding a button high produces exactly one action.

## Configuration
- `GOMOKU_UNDO_EN`:
  - Defined: the undo history buffer and the undo behaviour above are compiled in.
  - Undefined: the history buffer is omitted, the `undo` port remains but is ignored, and OVER is left only by reset.

## Test plan
- Reset then 3 right edges, 1 up edge with MAP_N=10 → `cursor_pos` = 55 → 58 → 48; board all zero; `turn` = 0.
- Cursor at 0, press left then up → `cursor_pos` stays 0. Cursor at 99, press right then down → stays 99.
- Put at 55 → `put_ack` at E, bits [111:110] = 01, `busy` high E..E+3, `turn` = 1 at E+4. A second put at 55 → `put_nack`, board unchanged.
- Black at 50,51,52,53,54 with white elsewhere, placed alternately → after the 5th black put, at E+4 `winner` = 01 and `game_over` = 1. A further put → `put_nack`.
- Diagonal ↗ white win at 90,81,72,63,54 → `winner` = 10. Four stones plus an edge → no win.
- With `GOMOKU_UNDO_EN`, 10 puts then 9 undos (UNDO_DEPTH=8):
  - The first 8 undos clear the last 8 cells in reverse order; the 9th is ignored.
  - An undo in OVER clears `winner` and the last stone and returns `turn` to its colour.
